// File: rtl/tensor_core_result_buffer.sv
// tensor_core_result_buffer
// Collects result bytes from the tensor core controller during read bursts.
// Each pair of bytes becomes one 16-bit word, high byte first. Words are queued
// in a FIFO that a host-side consumer drains over a valid/ready handshake.
// Optional build macro TENSOR_RESULT_SEQ_TAG_EN adds result_tag_out. This is a
// 4-bit burst sequence number that is stored with every word.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for a BURST READ / READ_AND_WRITE instruction
// CAPTURE_HI | next valid beat supplies the high byte of a word
// CAPTURE_LO | next valid beat supplies the low byte; the word is pushed
module tensor_core_result_buffer #(
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 5
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     instr_valid_in,
    input  logic [15:0]              current_tensor_core_instruction,
    input  logic [7:0]               tensor_core_controller_output,
    output logic [15:0]              result_data_out,
    output logic                     result_valid_out,
    input  logic                     result_ready_in,
    output logic [$clog2(DEPTH):0]   fifo_count_out,
    output logic                     busy_out,
    output logic                     overflow_out
`ifdef TENSOR_RESULT_SEQ_TAG_EN
    ,
    output logic [3:0]               result_tag_out
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_LOAD = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CAPTURE_HI = 2'd1,
        CAPTURE_LO = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  words_left_q, words_left_d;
    logic [7:0]     hold_q, hold_d;

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic           wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    mem_q [DEPTH];

    logic [1:0]     opcode;
    logic [1:0]     burst_sel;
    logic           flush;
    logic           is_start;
    logic           start_burst;
    logic           push_req;
    logic           push_ok;
    logic           pop;
    logic           ovf_set;
    logic           empty;
    logic           full;
    logic [AW:0]    count;
    logic           unused_instr_bits;

    assign opcode            = current_tensor_core_instruction[1:0];
    assign burst_sel         = current_tensor_core_instruction[3:2];
    assign unused_instr_bits = ^current_tensor_core_instruction[15:4];

    // RESET opcode flushes everything and overrides any push or pop on the same beat
    assign flush    = instr_valid_in && (opcode == 2'b11);
    assign is_start = instr_valid_in && (opcode == 2'b10) &&
                      ((burst_sel == 2'b00) || (burst_sel == 2'b10));

    assign count   = {wr_wrap_q, wr_ptr_q} - {rd_wrap_q, rd_ptr_q};
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = !empty && result_ready_in && !flush;
    // A full FIFO still takes the word if the head leaves on the same edge
    assign push_ok = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    // Capture FSM: next state, byte hold and burst word down-counter
    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        hold_d       = hold_q;
        push_req     = 1'b0;
        start_burst  = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else if (instr_valid_in) begin
            case (state_q)
                IDLE: begin
                    if (is_start) begin
                        state_d      = CAPTURE_HI;
                        words_left_d = LAST_LOAD;
                        start_burst  = 1'b1;
                    end
                end
                CAPTURE_HI: begin
                    hold_d  = tensor_core_controller_output;
                    state_d = CAPTURE_LO;
                end
                CAPTURE_LO: begin
                    push_req = 1'b1;
                    if (words_left_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        words_left_d = words_left_q - CW'(1);
                        state_d      = CAPTURE_HI;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO pointer and sticky overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        wr_wrap_d  = wr_wrap_q;
        rd_ptr_d   = rd_ptr_q;
        rd_wrap_d  = rd_wrap_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            wr_wrap_d  = 1'b0;
            rd_ptr_d   = '0;
            rd_wrap_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                {wr_wrap_d, wr_ptr_d} = {wr_wrap_q, wr_ptr_q} + (AW+1)'(1);
            end
            if (pop) begin
                {rd_wrap_d, rd_ptr_d} = {rd_wrap_q, rd_ptr_q} + (AW+1)'(1);
            end
            if (ovf_set) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            hold_q       <= '0;
            wr_ptr_q     <= '0;
            wr_wrap_q    <= 1'b0;
            rd_ptr_q     <= '0;
            rd_wrap_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            hold_q       <= hold_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_wrap_q    <= wr_wrap_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_wrap_q    <= rd_wrap_d;
            overflow_q   <= overflow_d;
        end
    end

    // Word storage; stale entries are never visible because the output is gated by empty
    always_ff @(posedge clock_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {hold_q, tensor_core_controller_output};
        end
    end

    assign result_valid_out = !empty;
    assign result_data_out  = empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign fifo_count_out   = count;
    assign busy_out         = (state_q != IDLE);
    assign overflow_out     = overflow_q;

`ifdef TENSOR_RESULT_SEQ_TAG_EN
    logic [3:0] seq_q, seq_d;
    logic [3:0] burst_tag_q, burst_tag_d;
    logic [3:0] tag_mem_q [DEPTH];

    // Sequence counter advances on each burst start; the burst keeps the pre-increment value
    always_comb begin
        seq_d       = seq_q;
        burst_tag_d = burst_tag_q;
        if (flush) begin
            seq_d = 4'd0;
        end else if (start_burst) begin
            burst_tag_d = seq_q;
            seq_d       = seq_q + 4'd1;
        end
    end

    // Sequence tag registers
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            seq_q       <= 4'd0;
            burst_tag_q <= 4'd0;
        end else begin
            seq_q       <= seq_d;
            burst_tag_q <= burst_tag_d;
        end
    end

    // Tag storage alongside each word
    always_ff @(posedge clock_in) begin
        if (push_ok) begin
            tag_mem_q[wr_ptr_q] <= burst_tag_q;
        end
    end

    assign result_tag_out = empty ? 4'd0 : tag_mem_q[rd_ptr_q];
`else
    logic unused_start_burst;
    assign unused_start_burst = start_burst;
`endif

endmodule

// File: tb/tb_tensor_core_result_buffer.sv
// Bench for tensor_core_result_buffer (DEPTH=4, BURST_LEN=5). Expected words
// are queued as bytes are driven. They are popped and compared when the DUT
// hands a word to the consumer.
module tb_tensor_core_result_buffer;

    localparam int DEPTH     = 4;
    localparam int BURST_LEN = 5;
    localparam int CNTW      = $clog2(DEPTH) + 1;

    logic            clock_in = 1'b0;
    logic            reset_in;
    logic            instr_valid_in;
    logic [15:0]     current_tensor_core_instruction;
    logic [7:0]      tensor_core_controller_output;
    logic [15:0]     result_data_out;
    logic            result_valid_out;
    logic            result_ready_in;
    logic [CNTW-1:0] fifo_count_out;
    logic            busy_out;
    logic            overflow_out;
    logic [3:0]      tag_obs;

    tensor_core_result_buffer #(.DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
        .clock_in                        (clock_in),
        .reset_in                        (reset_in),
        .instr_valid_in                  (instr_valid_in),
        .current_tensor_core_instruction (current_tensor_core_instruction),
        .tensor_core_controller_output   (tensor_core_controller_output),
        .result_data_out                 (result_data_out),
        .result_valid_out                (result_valid_out),
        .result_ready_in                 (result_ready_in),
        .fifo_count_out                  (fifo_count_out),
        .busy_out                        (busy_out),
        .overflow_out                    (overflow_out)
`ifdef TENSOR_RESULT_SEQ_TAG_EN
        ,
        .result_tag_out                  (tag_obs)
`endif
    );

`ifndef TENSOR_RESULT_SEQ_TAG_EN
    assign tag_obs = 4'h0;
`endif

    always #5 clock_in = ~clock_in;

    int              vectors     = 0;
    int              miscompares = 0;
    logic [19:0]     q[$];
    logic            m_ovf = 1'b0;
    logic [3:0]      mseq  = 4'd0;
    logic [3:0]      mtag  = 4'd0;
    logic [CNTW+2:0] exp_st;
    logic [CNTW+2:0] got_st;

    // One clock of stimulus, driven at the falling edge; the model advances to the next rising edge.
    task automatic cyc(input logic v, input logic [15:0] ins, input logic [7:0] b, input logic r,
                       input logic push, input logic [15:0] w,
                       output logic pv, output logic mp, output logic [19:0] pd, output logic [19:0] ed);
        logic fl;
        @(negedge clock_in);
        instr_valid_in                  = v;
        current_tensor_core_instruction = ins;
        tensor_core_controller_output   = b;
        result_ready_in                 = r;
        fl = v && (ins[1:0] == 2'b11);
        pv = result_valid_out && r && !fl;
        pd = {tag_obs, result_data_out};
        ed = 'x;
        mp = 1'b0;
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
            mseq  = 4'd0;
        end else begin
            mp = (q.size() > 0) && r;
            if (mp) ed = q.pop_front();
            if (push) begin
                if (q.size() == DEPTH) m_ovf = 1'b1;
`ifdef TENSOR_RESULT_SEQ_TAG_EN
                else q.push_back({mtag, w});
`else
                else q.push_back({4'h0, w});
`endif
            end
        end
    endtask

    task automatic idle(input int n, input logic r);
        logic pv, mp;
        logic [19:0] pd, ed;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 16'h0000, 8'h00, r, 1'b0, 16'h0000, pv, mp, pd, ed);
            if (pv || mp) begin
                vectors++;
                if (pv !== mp || pd !== ed) begin
                    miscompares++;
                    $display("FAIL pop_word: got valid=%b tag/data=%h, expected valid=%b tag/data=%h", pv, pd, mp, ed);
                end
            end
        end
    endtask

    // Start beat plus nbytes data beats; data beats carry a BURST opcode that must be ignored.
    task automatic burst(input logic [7:0] first, input bit gapped, input logic r, input logic r_last, input int nbytes);
        logic pv, mp, rr;
        logic [19:0] pd, ed;
        logic [7:0] hold, b;
        hold = 8'h00;
        cyc(1'b1, 16'h0002, 8'h5A, r, 1'b0, 16'h0000, pv, mp, pd, ed);
        if (pv || mp) begin
            vectors++;
            if (pv !== mp || pd !== ed) begin
                miscompares++;
                $display("FAIL pop_word: got valid=%b tag/data=%h, expected valid=%b tag/data=%h", pv, pd, mp, ed);
            end
        end
        mtag = mseq;
        mseq = mseq + 4'd1;
        for (int k = 0; k < nbytes; k++) begin
            if (gapped) begin
                cyc(1'b0, 16'h0003, 8'hEE, r, 1'b0, 16'h0000, pv, mp, pd, ed);
                if (pv || mp) begin
                    vectors++;
                    if (pv !== mp || pd !== ed) begin
                        miscompares++;
                        $display("FAIL pop_word: got valid=%b tag/data=%h, expected valid=%b tag/data=%h", pv, pd, mp, ed);
                    end
                end
            end
            b  = first + 8'(k);
            rr = (k == 2*BURST_LEN - 1) ? r_last : r;
            cyc(1'b1, 16'h0002, b, rr, k[0], {hold, b}, pv, mp, pd, ed);
            if (pv || mp) begin
                vectors++;
                if (pv !== mp || pd !== ed) begin
                    miscompares++;
                    $display("FAIL pop_word: got valid=%b tag/data=%h, expected valid=%b tag/data=%h", pv, pd, mp, ed);
                end
            end
            if (!k[0]) hold = b;
            if (k == 0) begin
                vectors++;
                if (busy_out !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_after_start: got %b expected 1", busy_out);
                end
            end
        end
        if (nbytes == 2*BURST_LEN) begin
            cyc(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, pv, mp, pd, ed);
            vectors++;
            if (busy_out !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_after_last_word: got %b expected 0", busy_out);
            end
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        instr_valid_in = 1'b0;
        current_tensor_core_instruction = 16'h0000;
        tensor_core_controller_output = 8'h00;
        result_ready_in = 1'b0;
        #1 reset_in = 1'b0;
        #2;
        vectors++;
        if ({busy_out, result_valid_out, overflow_out, fifo_count_out, result_data_out, tag_obs} !==
            {1'b0, 1'b0, 1'b0, CNTW'(0), 16'h0000, 4'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b valid=%b ovf=%b count=%0d data=%h tag=%h, expected all zero",
                     busy_out, result_valid_out, overflow_out, fifo_count_out, result_data_out, tag_obs);
        end
        @(negedge clock_in);
        @(negedge clock_in);
        reset_in = 1'b1;
    endtask

    task automatic test_read_burst();
        burst(8'h11, 1'b0, 1'b1, 1'b1, 2*BURST_LEN);
        idle(3, 1'b1);
        idle(1, 1'b0);
        vectors++;
        exp_st = {1'b0, 1'b0, m_ovf, CNTW'(q.size())};
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st) begin
            miscompares++;
            $display("FAIL read_burst_drained: busy/valid/ovf/count got %b expected %b", got_st, exp_st);
        end
    endtask

    task automatic test_gapped();
        burst(8'h11, 1'b1, 1'b1, 1'b1, 2*BURST_LEN);
        idle(3, 1'b1);
        idle(1, 1'b0);
        vectors++;
        exp_st = {1'b0, 1'b0, m_ovf, CNTW'(q.size())};
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st) begin
            miscompares++;
            $display("FAIL gapped_drained: busy/valid/ovf/count got %b expected %b", got_st, exp_st);
        end
    endtask

    task automatic test_overflow();
        logic pv, mp;
        logic [19:0] pd, ed;
        burst(8'h21, 1'b0, 1'b0, 1'b0, 2*BURST_LEN);
        vectors++;
        exp_st = {1'b0, 1'b1, 1'b1, CNTW'(DEPTH)};
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st || m_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_full: busy/valid/ovf/count got %b expected %b", got_st, exp_st);
        end
        idle(6, 1'b1);
        idle(1, 1'b0);
        vectors++;
        exp_st = {1'b0, 1'b0, 1'b1, CNTW'(0)};
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st) begin
            miscompares++;
            $display("FAIL overflow_drained_sticky: busy/valid/ovf/count got %b expected %b", got_st, exp_st);
        end
        cyc(1'b1, 16'h0003, 8'h99, 1'b0, 1'b0, 16'h0000, pv, mp, pd, ed);
        idle(1, 1'b0);
        vectors++;
        exp_st = {1'b0, 1'b0, 1'b0, CNTW'(0)};
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st) begin
            miscompares++;
            $display("FAIL overflow_cleared_by_flush: busy/valid/ovf/count got %b expected %b", got_st, exp_st);
        end
    endtask

    task automatic test_full_push_pop();
        burst(8'h31, 1'b0, 1'b0, 1'b1, 2*BURST_LEN);
        vectors++;
        exp_st = {1'b0, 1'b1, 1'b0, CNTW'(DEPTH)};
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st) begin
            miscompares++;
            $display("FAIL full_push_pop: busy/valid/ovf/count got %b expected %b", got_st, exp_st);
        end
        idle(6, 1'b1);
        idle(1, 1'b0);
        vectors++;
        exp_st = {1'b0, 1'b0, 1'b0, CNTW'(0)};
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st) begin
            miscompares++;
            $display("FAIL full_push_pop_drained: busy/valid/ovf/count got %b expected %b", got_st, exp_st);
        end
    endtask

    task automatic test_flush_mid_burst();
        logic pv, mp;
        logic [19:0] pd, ed;
        burst(8'h41, 1'b0, 1'b0, 1'b0, 3);
        vectors++;
        exp_st = {1'b1, 1'b1, 1'b0, CNTW'(1)};
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st) begin
            miscompares++;
            $display("FAIL partial_burst: busy/valid/ovf/count got %b expected %b", got_st, exp_st);
        end
        cyc(1'b1, 16'h0003, 8'h44, 1'b1, 1'b0, 16'h0000, pv, mp, pd, ed);
        idle(1, 1'b0);
        vectors++;
        exp_st = {1'b0, 1'b0, 1'b0, CNTW'(0)};
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st) begin
            miscompares++;
            $display("FAIL flush_mid_burst: busy/valid/ovf/count got %b expected %b", got_st, exp_st);
        end
        burst(8'h51, 1'b0, 1'b1, 1'b1, 2*BURST_LEN);
        idle(3, 1'b1);
        idle(1, 1'b0);
        vectors++;
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st) begin
            miscompares++;
            $display("FAIL burst_after_flush_drained: busy/valid/ovf/count got %b expected %b", got_st, exp_st);
        end
    endtask

    task automatic test_async_reset_and_write_burst();
        logic pv, mp;
        logic [19:0] pd, ed;
        burst(8'h61, 1'b0, 1'b0, 1'b0, 3);
        idle(1, 1'b0);
        #2 reset_in = 1'b0;
        #1;
        vectors++;
        if ({busy_out, result_valid_out, overflow_out, fifo_count_out, result_data_out, tag_obs} !==
            {1'b0, 1'b0, 1'b0, CNTW'(0), 16'h0000, 4'h0}) begin
            miscompares++;
            $display("FAIL async_reset_outputs: busy=%b valid=%b ovf=%b count=%0d data=%h tag=%h, expected all zero",
                     busy_out, result_valid_out, overflow_out, fifo_count_out, result_data_out, tag_obs);
        end
        q.delete();
        m_ovf = 1'b0;
        mseq  = 4'd0;
        #1 reset_in = 1'b1;
        cyc(1'b1, 16'h0006, 8'h77, 1'b0, 1'b0, 16'h0000, pv, mp, pd, ed);
        cyc(1'b1, 16'h000E, 8'h78, 1'b0, 1'b0, 16'h0000, pv, mp, pd, ed);
        cyc(1'b1, 16'h0001, 8'h79, 1'b0, 1'b0, 16'h0000, pv, mp, pd, ed);
        cyc(1'b1, 16'h0000, 8'h7A, 1'b0, 1'b0, 16'h0000, pv, mp, pd, ed);
        idle(1, 1'b0);
        vectors++;
        exp_st = {1'b0, 1'b0, 1'b0, CNTW'(0)};
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st) begin
            miscompares++;
            $display("FAIL write_burst_ignored: busy/valid/ovf/count got %b expected %b", got_st, exp_st);
        end
    endtask

    task automatic test_tags();
        burst(8'h71, 1'b0, 1'b1, 1'b1, 2*BURST_LEN);
        burst(8'h81, 1'b0, 1'b1, 1'b1, 2*BURST_LEN);
        idle(3, 1'b1);
        idle(1, 1'b0);
        vectors++;
        exp_st = {1'b0, 1'b0, 1'b0, CNTW'(0)};
        got_st = {busy_out, result_valid_out, overflow_out, fifo_count_out};
        if (got_st !== exp_st || tag_obs !== 4'h0) begin
            miscompares++;
            $display("FAIL tags_drained: busy/valid/ovf/count got %b tag %h expected %b tag 0", got_st, tag_obs, exp_st);
        end
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_gapped();
        test_overflow();
        test_full_push_pop();
        test_flush_mid_burst();
        test_async_reset_and_write_burst();
        test_tags();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
